// File: rtl/qspi_fetch_buffer.sv
// Direct-mapped read-only line buffer for XIP fetch from QSPI flash; hits answer in 1 cycle,
// misses issue one APB-style 64-bit line read, fill the line and answer the cycle after m_pready.
module qspi_fetch_buffer #(
  parameter int LINES = 8,
  parameter int CNT_W = 16
) (
  input  logic             s_pclk,
  input  logic             s_presetn,
  input  logic             f_req_valid,
  output logic             f_req_ready,
  input  logic [23:0]      f_req_addr,
  output logic             f_rsp_valid,
  output logic [31:0]      f_rsp_data,
  input  logic             inv_i,
  output logic [31:0]      m_paddr,
  output logic             m_psel,
  output logic             m_penable,
  output logic             m_pwrite,
  input  logic             m_pready,
  input  logic [63:0]      m_prdata,
  output logic [CNT_W-1:0] miss_cnt
);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 21 - IDX_W;

  typedef enum logic [2:0] {IDLE, HIT_RSP, FILL_SETUP, FILL_ACCESS, FILL_RSP} state_t;

  state_t            state_q, state_d;
  logic [LINES-1:0]  vld_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [63:0]       data_q [LINES];
  logic [23:2]       addr_q;
  logic              inv_pend_q;

  logic [IDX_W-1:0]  req_idx, fill_idx;
  logic [TAG_W-1:0]  req_tag, fill_tag;
  logic [63:0]       rd_line;
  logic [31:0]       hit_word;
  logic              accept, hit, fill_done;
  logic              unused_addr;

  assign unused_addr = &{1'b0, f_req_addr[1:0]};

  assign req_idx  = f_req_addr[3 +: IDX_W];
  assign req_tag  = f_req_addr[23 : 3+IDX_W];
  assign fill_idx = addr_q[3 +: IDX_W];
  assign fill_tag = addr_q[23 : 3+IDX_W];
  assign rd_line  = data_q[req_idx];
  assign hit_word = f_req_addr[2] ? rd_line[63:32] : rd_line[31:0];

  assign accept    = f_req_valid && f_req_ready;
  // An invalidate coinciding with the accept forces a miss.
  assign hit       = vld_q[req_idx] && (tag_q[req_idx] == req_tag) && !inv_i;
  assign fill_done = (state_q == FILL_ACCESS) && m_pready;
  assign m_pwrite  = 1'b0;

  always_comb begin
    state_d     = state_q;
    f_req_ready = 1'b0;
    f_rsp_valid = 1'b0;
    m_psel      = 1'b0;
    m_penable   = 1'b0;
    case (state_q)
      IDLE: begin
        f_req_ready = 1'b1;
        if (f_req_valid) state_d = hit ? HIT_RSP : FILL_SETUP;
      end
      HIT_RSP: begin
        f_rsp_valid = 1'b1;
        state_d     = IDLE;
      end
      FILL_SETUP: begin
        m_psel  = 1'b1;
        state_d = FILL_ACCESS;
      end
      FILL_ACCESS: begin
        m_psel    = 1'b1;
        m_penable = 1'b1;
        if (m_pready) state_d = FILL_RSP;
      end
      FILL_RSP: begin
        f_rsp_valid = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge s_pclk or negedge s_presetn) begin
    if (!s_presetn) begin
      state_q    <= IDLE;
      vld_q      <= '0;
      addr_q     <= '0;
      inv_pend_q <= 1'b0;
      f_rsp_data <= '0;
      m_paddr    <= '0;
      miss_cnt   <= '0;
    end else begin
      state_q <= state_d;
      if (inv_i) vld_q <= '0;
      if (accept) begin
        addr_q     <= f_req_addr[23:2];
        inv_pend_q <= 1'b0;
        if (hit) begin
          f_rsp_data <= hit_word;
        end else begin
          m_paddr <= {8'h00, f_req_addr[23:3], 3'b000};
          if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
        end
      end
      // Remember an invalidate seen while the fill is in flight so the new line lands invalid.
      if (inv_i && (state_q == FILL_SETUP || state_q == FILL_ACCESS)) inv_pend_q <= 1'b1;
      if (fill_done) begin
        vld_q[fill_idx] <= !(inv_i || inv_pend_q);
        f_rsp_data      <= addr_q[2] ? m_prdata[63:32] : m_prdata[31:0];
      end
    end
  end

  always_ff @(posedge s_pclk) begin
    if (fill_done) begin
      data_q[fill_idx] <= m_prdata;
      tag_q[fill_idx]  <= fill_tag;
    end
  end
endmodule

// File: doc/qspi_fetch_buffer.md
Name: qspi_fetch_buffer

Overview:
- Direct-mapped, read-only line buffer for execute-in-place instruction fetch from QSPI flash.
- Sits between the core fetch port (upstream) and the QSPI flash read controller (downstream, APB-style slave returning one 64-bit line per read).
- Hits return a 32-bit word without touching flash. Misses issue one line read to the controller, fill the buffer, then return the requested word.

Parameters:
- LINES, 8, number of 8-byte lines; power of two, at least 2.
- CNT_W, 16, width of the saturating miss counter.

Ports:
- s_pclk  input  1  clock
- s_presetn  input  1  asynchronous active-low reset
- f_req_valid  input  1  fetch request valid
- f_req_ready  output  1  fetch request accepted when valid and ready are both high
- f_req_addr  input  24  byte address; bits [1:0] ignored
- f_rsp_valid  output  1  one-cycle response strobe; the consumer always accepts it
- f_rsp_data  output  32  fetched word
- inv_i  input  1  invalidate all lines
- m_paddr  output  32  {8'h00, line address[23:3], 3'b000}
- m_psel  output  1  APB select
- m_penable  output  1  APB enable
- m_pwrite  output  1  tied 0
- m_pready  input  1  controller done; m_prdata valid in the same cycle
- m_prdata  input  64  line data; flash byte k sits in bits [8k+7:8k]
- miss_cnt  output  CNT_W  saturating count of misses

Behaviour:
- Reset (s_presetn asynchronous, active-low; clock s_pclk):
  - state IDLE, all valid bits 0;
  - f_req_ready=1, f_rsp_valid=0, f_rsp_data=0;
  - m_psel=0, m_penable=0, m_paddr=0, miss_cnt=0.
- Address split:
  - offset = addr[2];
  - index = addr[3 +: log2(LINES)];
  - tag = addr[23 : 3+log2(LINES)].
- Storage: per line, a valid bit, a tag and 64 data bits, in flops. Word select: offset 0 returns bits [31:0], offset 1 returns bits [63:32].
- f_req_ready = 1 only in IDLE.
- f_rsp_data is registered and holds its last value while f_rsp_valid=0.
- IDLE:
  - On accept, register the address.
  - Hit (valid[index] and tag match, evaluated at the accept edge): go to HIT_RSP.
  - Otherwise: go to FILL_SETUP and increment miss_cnt; miss_cnt saturates at all-ones.
- HIT_RSP (one cycle): f_rsp_valid=1, f_rsp_data = selected word; then IDLE. Hit latency is 1 cycle; hit throughput is 1 request per 2 cycles.
- FILL_SETUP (one cycle): m_psel=1, m_penable=0, m_paddr driven from the registered address; then FILL_ACCESS.
- FILL_ACCESS:
  - m_psel=1, m_penable=1; hold until m_pready=1. No timeout.
  - On the m_pready edge: write m_prdata and the tag into the line, set its valid bit, capture the requested word; then FILL_RSP.
- FILL_RSP (one cycle): m_psel=0, f_rsp_valid=1; then IDLE.
  - m_psel must be 0 in the cycle after m_pready, so the controller does not start a second read.
- m_paddr holds its value outside a fill; m_pwrite is always 0.
- Invalidate:
  - inv_i=1 clears all valid bits at the next edge, in any state.
  - inv_i and an accept in the same IDLE cycle: the request is treated as a miss.
  - inv_i during FILL_SETUP or FILL_ACCESS: the pending fill completes and the requester gets the data, but the line is written with valid=0.
  - inv_i on the m_pready edge itself: valid is written 0.
- Refill of an occupied index overwrites it (no replacement policy).
- Reset mid-fill: everything returns to reset values immediately, m_psel drops asynchronously, and no response is produced. The controller shares the reset.
- Misses on the same line back-to-back: the first fills the line; the second request, accepted after it, hits.

Test Plan:
- Cold miss, then same-line hit:
  - Fetch 0x000100 with m_prdata=0x1122334455667788 and m_pready 20 cycles after FILL_ACCESS entry -> m_paddr=0x00000100; psel/penable follow the setup/access sequence; f_rsp_data=0x55667788 one cycle after m_pready; miss_cnt=1.
  - Then fetch 0x000104 -> f_rsp_data=0x11223344 one cycle after accept; m_psel stays 0; miss_cnt stays 1.
- Conflict (LINES=8):
  - Fill 0x000000, then fetch 0x000040 (same index, different tag) -> miss, m_paddr=0x00000040, miss_cnt=2.
  - Then fetch 0x000000 again -> miss again, miss_cnt=3.
- Invalidate during fill:
  - Assert inv_i for one cycle in FILL_ACCESS -> the requester still receives the word; a repeat fetch of the same address misses.
  - Invalidate in IDLE together with an accepted hit-address -> treated as a miss.
- Handshake hold:
  - m_pready delayed 100 cycles -> m_psel=1 and m_penable=1 held throughout; f_req_ready=0; m_psel=0 in the cycle after m_pready.
- Reset mid-fill:
  - Deassert s_presetn in FILL_ACCESS -> m_psel=0 immediately, no f_rsp_valid, all lines invalid, miss_cnt=0.
  - After release, a fetch of 0x000100 misses.
- Saturation:
  - With CNT_W=4, issue 20 misses -> miss_cnt stops at 0xF.
